// File: rtl/serial_pkg.sv
// Shared definitions for the lab 4 serial link (transmitter and receiver).
// Holds the frame state encoding, line levels and the parity helper.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/serial_char_transmitter_bit_timer.sv
// Bit-period counter shared by the serial transmitter and receiver.
// Counts 0..BIT_CLKS-1 while run is high and wraps at each bit boundary.
module bit_timer #(
   parameter int BIT_CLKS = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic run,
   output logic bit_done,
   output logic bit_pre_done
);

   localparam logic [15:0] LAST = 16'(BIT_CLKS - 1);
   localparam logic [15:0] PRE  = 16'(BIT_CLKS - 2);

   logic [15:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (restart) begin
         r_count <= '0;
      end else if (run) begin
         r_count <= (r_count == LAST) ? '0 : r_count + 16'd1;
      end
   end

   // bit_pre_done leads bit_done by one cycle so callers can register flags
   // that must coincide with the final cycle of a bit.
   assign bit_done     = run & ~restart & (r_count == LAST);
   assign bit_pre_done = run & ~restart & (r_count == PRE);

endmodule

// File: rtl/serial_char_transmitter.sv
// Serial character transmitter: one-byte holding register feeding a framed,
// LSB-first shifter with optional even parity and back-to-back frames.
module serial_char_transmitter
   import serial_pkg::*;
#(
   parameter int BIT_CLKS  = 16,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   input  logic [DATA_BITS-1:0] data_bus_out_port,
   input  logic                 load_export,
   input  logic                 transmit_enable_export,
   output logic                 character_sent_export,
   output logic                 serial_out,
   output logic                 busy,
   output logic                 holding_full
);

   state_t               r_state;
   logic [DATA_BITS-1:0] r_hold;
   logic [DATA_BITS-1:0] r_shift;
   logic [2:0]           r_bit_idx;
   logic                 r_parity;
   logic                 r_holding_full;
   logic                 r_serial_out;
   logic                 r_busy;
   logic                 r_char_sent;

   logic w_start_ok;
   logic w_bit_done;
   logic w_bit_pre_done;

   assign w_start_ok = r_holding_full & transmit_enable_export;

   bit_timer #(
      .BIT_CLKS(BIT_CLKS)
   ) u_bit_timer (
      .clk         (clk_clk),
      .rst         (reset_reset),
      .restart     (r_state == IDLE),
      .run         (r_state != IDLE),
      .bit_done    (w_bit_done),
      .bit_pre_done(w_bit_pre_done)
   );

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state        <= IDLE;
         r_hold         <= '0;
         r_shift        <= '0;
         r_bit_idx      <= '0;
         r_parity       <= 1'b0;
         r_holding_full <= 1'b0;
         r_serial_out   <= IDLE_LEVEL;
         r_busy         <= 1'b0;
         r_char_sent    <= 1'b0;
      end else begin
         r_char_sent <= (r_state == STOP) & w_bit_pre_done;

         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  r_state        <= START;
                  r_shift        <= r_hold;
                  r_parity       <= even_parity(r_hold);
                  r_holding_full <= 1'b0;
                  r_serial_out   <= START_LEVEL;
                  r_busy         <= 1'b1;
               end
            end
            START: begin
               if (w_bit_done) begin
                  r_state      <= DATA;
                  r_bit_idx    <= '0;
                  r_serial_out <= r_shift[0];
               end
            end
            DATA: begin
               if (w_bit_done) begin
                  if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                     r_bit_idx <= '0;
                     if (PARITY_EN) begin
                        r_state      <= PARITY;
                        r_serial_out <= r_parity;
                     end else begin
                        r_state      <= STOP;
                        r_serial_out <= IDLE_LEVEL;
                     end
                  end else begin
                     r_bit_idx    <= r_bit_idx + 3'd1;
                     r_serial_out <= r_shift[r_bit_idx + 3'd1];
                  end
               end
            end
            PARITY: begin
               if (w_bit_done) begin
                  r_state      <= STOP;
                  r_serial_out <= IDLE_LEVEL;
               end
            end
            STOP: begin
               if (w_bit_done) begin
                  if (w_start_ok) begin
                     r_state        <= START;
                     r_shift        <= r_hold;
                     r_parity       <= even_parity(r_hold);
                     r_holding_full <= 1'b0;
                     r_serial_out   <= START_LEVEL;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase

         // NOTE: non-blocking semantics let this later write win over the clear
         // above, while the frame start still copies the old held byte.
         if (load_export) begin
            r_hold         <= data_bus_out_port;
            r_holding_full <= 1'b1;
         end
      end
   end

   assign character_sent_export = r_char_sent;
   assign serial_out            = r_serial_out;
   assign busy                  = r_busy;
   assign holding_full          = r_holding_full;

endmodule

// File: tb/tb_serial_char_transmitter.sv
// Self-checking bench: two transmitters (parity off / on) share stimulus and are
// compared every cycle against a frame-waveform model plus literal frame patterns.
module tb_serial_char_transmitter;

   localparam int B = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load;
   logic [7:0] data;

   logic ser0, busy0, hf0, cs0;
   logic ser1, busy1, hf1, cs1;

   int n_checks = 0;
   int n_errors = 0;
   int lat;

   always #5 clk = ~clk;

   serial_char_transmitter #(.BIT_CLKS(B), .PARITY_EN(1'b0)) dut0 (
      .clk_clk               (clk),
      .reset_reset           (rst),
      .data_bus_out_port     (data),
      .load_export           (load),
      .transmit_enable_export(en),
      .character_sent_export (cs0),
      .serial_out            (ser0),
      .busy                  (busy0),
      .holding_full          (hf0)
   );

   serial_char_transmitter #(.BIT_CLKS(B), .PARITY_EN(1'b1)) dut1 (
      .clk_clk               (clk),
      .reset_reset           (rst),
      .data_bus_out_port     (data),
      .load_export           (load),
      .transmit_enable_export(en),
      .character_sent_export (cs1),
      .serial_out            (ser1),
      .busy                  (busy1),
      .holding_full          (hf1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame is a list of line levels, each held B cycles; the model just
   // plays that list back and tracks the one-byte holding register.
   logic [7:0]  m_hold [2];
   logic        m_full [2];
   logic        m_act  [2];
   int          m_pos  [2];
   logic [10:0] m_lvl  [2];

   function automatic int flen(input int i);
      return (i == 1) ? 11 * B : 10 * B;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_hold[i] = '0;
            m_full[i] = 1'b0;
            m_act[i]  = 1'b0;
            m_pos[i]  = 0;
            m_lvl[i]  = '1;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_act[i] && m_pos[i] < flen(i) - 1) begin
               m_pos[i]++;
            end else if (m_full[i] && en) begin
               m_lvl[i]  = (i == 1) ? {1'b1, ^m_hold[i], m_hold[i], 1'b0}
                                    : {1'b1, 1'b1, m_hold[i], 1'b0};
               m_act[i]  = 1'b1;
               m_pos[i]  = 0;
               m_full[i] = 1'b0;
            end else begin
               m_act[i] = 1'b0;
            end
            if (load) begin
               m_hold[i] = data;
               m_full[i] = 1'b1;
            end
         end
      end
   end

   function automatic logic e_ser(input int i);
      return m_act[i] ? m_lvl[i][m_pos[i] / B] : 1'b1;
   endfunction

   function automatic logic e_cs(input int i);
      return m_act[i] && (m_pos[i] == flen(i) - 1);
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         check("model ser0",  ser0,  e_ser(0));
         check("model busy0", busy0, m_act[0]);
         check("model hf0",   hf0,   m_full[0]);
         check("model cs0",   cs0,   e_cs(0));
         check("model ser1",  ser1,  e_ser(1));
         check("model busy1", busy1, m_act[1]);
         check("model hf1",   hf1,   m_full[1]);
         check("model cs1",   cs1,   e_cs(1));
      end
   end

   logic cap_s [200];
   logic cap_c [200];

   task automatic load_byte(input logic [7:0] b);
      @(posedge clk); #2;
      data = b;
      load = 1'b1;
      @(posedge clk); #2;
      load = 1'b0;
   endtask

   // Waits (bounded) for the start bit on the chosen DUT, then records len cycles.
   task automatic capture(input int which, input int len, output int l);
      logic s;
      l = 0;
      s = 1'b1;
      while (s !== 1'b0 && l < 300) begin
         @(negedge clk);
         l++;
         s = (which == 0) ? ser0 : ser1;
      end
      check("start bit seen", s, 1'b0);
      cap_s[0] = s;
      cap_c[0] = (which == 0) ? cs0 : cs1;
      for (int i = 1; i < len; i++) begin
         @(negedge clk);
         cap_s[i] = (which == 0) ? ser0 : ser1;
         cap_c[i] = (which == 0) ? cs0 : cs1;
      end
   endtask

   task automatic check_frame(input string tag, input string pat, input int base);
      logic [3:0] v;
      logic [3:0] e;
      for (int k = 0; k < pat.len(); k++) begin
         for (int j = 0; j < B; j++) v[j] = cap_s[base + k * B + j];
         e = (pat[k] == "1") ? 4'hF : 4'h0;
         check($sformatf("%s bit%0d", tag, k), v, e);
      end
   endtask

   function automatic int first_pulse(input int from, input int to);
      for (int i = from; i < to; i++) if (cap_c[i] === 1'b1) return i;
      return -1;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy0 !== 1'b0 || busy1 !== 1'b0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle reached", {busy1, busy0}, 2'b00);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int pulses;
      rst  = 1'b1;
      en   = 1'b0;
      load = 1'b0;
      data = '0;
      #1;
      check("reset ser0",  ser0,  1'b1);
      check("reset busy0", busy0, 1'b0);
      check("reset hf0",   hf0,   1'b0);
      check("reset cs0",   cs0,   1'b0);
      check("reset ser1",  ser1,  1'b1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Single byte
      en = 1'b1;
      load_byte(8'hA5);
      capture(0, 40, lat);
      check("A latency", lat, 2);
      check_frame("A", "0101001011", 0);
      check("A sent idx", first_pulse(0, 40), 39);
      @(negedge clk);
      check("A busy after", busy0, 1'b0);
      wait_idle();

      // Back-to-back
      load_byte(8'h01);
      fork
         capture(0, 80, lat);
         begin
            repeat (12) @(posedge clk);
            load_byte(8'hFF);
         end
      join
      check("B latency", lat, 2);
      check_frame("B1", "0100000001", 0);
      check_frame("B2", "0111111111", 40);
      check("B sent1 idx", first_pulse(0, 80), 39);
      check("B sent2 idx", first_pulse(40, 80), 79);
      wait_idle();

      // Enable gating
      en = 1'b0;
      load_byte(8'h3C);
      repeat (100) @(posedge clk);
      #2;
      check("C held hf0", hf0, 1'b1);
      check("C held ser0", ser0, 1'b1);
      en = 1'b1;
      capture(0, 40, lat);
      check("C latency", lat, 2);
      check_frame("C", "0001111001", 0);
      wait_idle();

      // Overwrite while a frame is in progress
      load_byte(8'h80);
      fork
         capture(0, 80, lat);
         begin
            repeat (10) @(posedge clk);
            load_byte(8'h11);
            repeat (5) @(posedge clk);
            load_byte(8'h22);
         end
      join
      check_frame("D1", "0000000011", 0);
      check_frame("D2", "0010001001", 40);
      wait_idle();

      // Parity frame on the parity-enabled instance
      load_byte(8'h07);
      capture(1, 44, lat);
      check("E latency", lat, 2);
      check_frame("E", "01110000011", 0);
      check("E sent idx", first_pulse(0, 44), 43);
      wait_idle();

      // Reset during data bit 3 with a byte also waiting in holding
      load_byte(8'h52);
      capture(0, 18, lat);
      load_byte(8'hC3);
      #1;
      check("F pre ser0", ser0, 1'b0);
      check("F pre hf0",  hf0,  1'b1);
      rst = 1'b1;
      #1;
      check("F rst ser0",  ser0,  1'b1);
      check("F rst busy0", busy0, 1'b0);
      check("F rst hf0",   hf0,   1'b0);
      check("F rst cs0",   cs0,   1'b0);
      check("F rst ser1",  ser1,  1'b1);
      check("F rst hf1",   hf1,   1'b0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      pulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (cs0 === 1'b1 || cs1 === 1'b1 || ser0 !== 1'b1) pulses++;
      end
      check("F quiet after reset", pulses, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
